// File: rtl/sm_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sm_ram_arbiter_pkg
// Shared configuration for the multi-port shared data RAM.
//   - default port count and RAM depth
//   - word-index offset: byte address bits [1:0] are dropped
//   - data word type and the index-width helper used by the arbiter
// Optional bus-lock support is selected with the macro SM_RAM_ARB_LOCK_EN
// (left undefined by default: pure round-robin).
// ---------------------------------------------------------------------------
package sm_ram_arbiter_pkg;

    localparam int SM_RAM_ARB_PORTS = 2;
    localparam int SM_RAM_ARB_DEPTH = 64;
    localparam int WORD_OFS         = 2;
    localparam int DATA_W           = 32;

    typedef logic [DATA_W-1:0] word_t;

    // Width of a port index; a single-port build still needs one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sm_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sm_ram_arbiter_if
// Request/acknowledge bus between the CPU data ports and the shared RAM.
//   req   [PORTS]      access request, held until ack
//   we    [PORTS]      write enable, qualifies req
//   addr  [PORTS*32]   byte address, port i at [32*i +: 32]
//   wdata [PORTS*32]   write data
//   lock  [PORTS]      bus lock (used only with SM_RAM_ARB_LOCK_EN)
//   rdata [PORTS*32]   read data, valid in the ack cycle
//   ack   [PORTS]      one-cycle completion pulse
// master = requester side (CPU cores), slave = sm_ram_arbiter.
// ---------------------------------------------------------------------------
interface sm_ram_arbiter_if #(
    parameter int PORTS = sm_ram_arbiter_pkg::SM_RAM_ARB_PORTS
);
    import sm_ram_arbiter_pkg::*;

    logic [PORTS-1:0]        req;
    logic [PORTS-1:0]        we;
    logic [PORTS*DATA_W-1:0] addr;
    logic [PORTS*DATA_W-1:0] wdata;
    logic [PORTS-1:0]        lock;
    logic [PORTS*DATA_W-1:0] rdata;
    logic [PORTS-1:0]        ack;

    modport master (
        output req, we, addr, wdata, lock,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output rdata, ack
    );

endinterface

// File: rtl/sm_ram_arbiter_rr.sv
// ---------------------------------------------------------------------------
// sm_rr_arbiter
// Purely combinational round-robin picker. The priority pointer register
// lives in the parent.
//   eligible   [PORTS]  ports that may be granted this cycle
//   ptr        [IW]     first port to consider; search goes upward, wrapping
//   grant      [PORTS]  one-hot grant (all zero when nothing is eligible)
//   grantIdx   [IW]     index of the granted port
//   grantValid          a grant was made
// ---------------------------------------------------------------------------
module sm_rr_arbiter
    import sm_ram_arbiter_pkg::*;
#(
    parameter int PORTS = SM_RAM_ARB_PORTS,
    parameter int IW    = idxWidth(PORTS)
) (
    input  logic [PORTS-1:0] eligible,
    input  logic [IW-1:0]    ptr,
    output logic [PORTS-1:0] grant,
    output logic [IW-1:0]    grantIdx,
    output logic             grantValid
);

    int cand_s;

    // Scan PORTS candidates starting at ptr; the first eligible one wins.
    always_comb begin
        grant      = '0;
        grantIdx   = '0;
        grantValid = 1'b0;
        cand_s     = 32'sd0;
        for (int off = 0; off < PORTS; off++) begin
            cand_s = int'(ptr) + off;
            if (cand_s >= PORTS) begin
                cand_s = cand_s - PORTS;
            end else begin
                cand_s = cand_s;
            end
            if (!grantValid && eligible[cand_s]) begin
                grant[cand_s] = 1'b1;
                grantIdx      = cand_s[IW-1:0];
                grantValid    = 1'b1;
            end else begin
                grantValid = grantValid;
            end
        end
    end

endmodule

// File: rtl/sm_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sm_ram_arbiter
// N CPU data ports share one word-addressed 32-bit RAM through a round-robin
// arbiter. One access per cycle; the granted port sees ack (and, for reads,
// rdata) in the following cycle.
//   clk    system clock
//   rst_n  asynchronous active-low reset (ack, rdata, pointer, lock owner);
//          RAM contents are kept
//   bus    sm_ram_arbiter_if.slave: req/we/addr/wdata/lock in, rdata/ack out
// Word index = addr[2 +: AW]; higher address bits are ignored, so indices
// wrap modulo DEPTH.
// Optional: define SM_RAM_ARB_LOCK_EN to let a granted port holding lock=1
// keep exclusive ownership of the bus until it drops lock.
// ---------------------------------------------------------------------------
module sm_ram_arbiter
    import sm_ram_arbiter_pkg::*;
#(
    parameter int PORTS = SM_RAM_ARB_PORTS,
    parameter int DEPTH = SM_RAM_ARB_DEPTH,
    parameter int AW    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    sm_ram_arbiter_if.slave    bus
);

    localparam int IW = idxWidth(PORTS);

    logic [PORTS-1:0]        ack_r;
    logic [PORTS*DATA_W-1:0] rdata_r;
    logic [IW-1:0]           ptr_r;
    logic [IW-1:0]           ptrNext_s;

    logic [PORTS-1:0]        eligible_s;
    logic [PORTS-1:0]        grant_s;
    logic [IW-1:0]           grantIdx_s;
    logic                    grantValid_s;

    word_t                   selAddr_s;
    word_t                   selWData_s;
    logic                    selWe_s;
    logic [AW-1:0]           selIdx_s;
    word_t                   memRd_s;

    word_t                   mem_r [DEPTH];

`ifdef SM_RAM_ARB_LOCK_EN
    logic                    lockValid_r;
    logic [IW-1:0]           lockOwner_r;
    logic                    ownerActive_s;
    logic [PORTS-1:0]        ownerMask_s;

    // An owner only counts while it still holds lock; the cycle it drops
    // lock everyone is eligible again.
    always_comb begin
        ownerActive_s = lockValid_r & bus.lock[lockOwner_r];
        ownerMask_s   = '0;
        if (ownerActive_s) begin
            ownerMask_s[lockOwner_r] = 1'b1;
        end else begin
            ownerMask_s = '1;
        end
        // A port being acked is masked so its held req is not granted twice.
        eligible_s = bus.req & ~ack_r & ownerMask_s;
    end

    // Lock owner tracking: a grant with lock=1 (re)claims ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockValid_r <= 1'b0;
            lockOwner_r <= '0;
        end else if (grantValid_s && bus.lock[grantIdx_s]) begin
            lockValid_r <= 1'b1;
            lockOwner_r <= grantIdx_s;
        end else if (ownerActive_s) begin
            lockValid_r <= 1'b1;
            lockOwner_r <= lockOwner_r;
        end else begin
            lockValid_r <= 1'b0;
            lockOwner_r <= lockOwner_r;
        end
    end
`else
    logic unusedLock_s;

    // A port being acked is masked so its held req is not granted twice.
    always_comb begin
        eligible_s = bus.req & ~ack_r;
    end

    assign unusedLock_s = ^bus.lock;
`endif

    sm_rr_arbiter #(
        .PORTS (PORTS),
        .IW    (IW)
    ) u_rr (
        .eligible   (eligible_s),
        .ptr        (ptr_r),
        .grant      (grant_s),
        .grantIdx   (grantIdx_s),
        .grantValid (grantValid_s)
    );

    // One-hot AND-OR mux of the granted port's address, data and direction.
    always_comb begin
        selAddr_s  = '0;
        selWData_s = '0;
        selWe_s    = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_s[i]) begin
                selAddr_s  = selAddr_s  | bus.addr[DATA_W*i +: DATA_W];
                selWData_s = selWData_s | bus.wdata[DATA_W*i +: DATA_W];
                selWe_s    = selWe_s    | bus.we[i];
            end else begin
                selWe_s    = selWe_s;
            end
        end
    end

    assign selIdx_s = selAddr_s[WORD_OFS +: AW];
    assign memRd_s  = mem_r[selIdx_s];

    generate
        if (WORD_OFS + AW < DATA_W) begin : g_addrHi
            logic unusedAddr_s;
            assign unusedAddr_s = ^{selAddr_s[WORD_OFS-1:0], selAddr_s[DATA_W-1:WORD_OFS+AW]};
        end else begin : g_addrFull
            logic unusedAddr_s;
            assign unusedAddr_s = ^selAddr_s[WORD_OFS-1:0];
        end
    endgenerate

    // Pointer moves past the granted port; unchanged on an idle cycle.
    always_comb begin
        if (grantValid_s) begin
            if (grantIdx_s == IW'(PORTS - 1)) begin
                ptrNext_s = '0;
            end else begin
                ptrNext_s = grantIdx_s + IW'(1);
            end
        end else begin
            ptrNext_s = ptr_r;
        end
    end

    // Ack pulse and round-robin pointer; reset discards a pending grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= '0;
            ptr_r <= '0;
        end else begin
            ack_r <= grant_s;
            ptr_r <= ptrNext_s;
        end
    end

    // Per-port read data, held until that port's next read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (grant_s[i] && !selWe_s) begin
                    rdata_r[DATA_W*i +: DATA_W] <= memRd_s;
                end
            end
        end
    end

    // RAM array: no reset, contents survive rst_n.
    always_ff @(posedge clk) begin
        if (grantValid_s && selWe_s) begin
            mem_r[selIdx_s] <= selWData_s;
        end
    end

    assign bus.ack   = ack_r;
    assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_sm_ram_arbiter.sv
module tb_sm_ram_arbiter;
    import sm_ram_arbiter_pkg::*;

    localparam int PORTS = 2;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef struct {
        int          port;
        bit          isRead;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sm_ram_arbiter_if #(.PORTS(PORTS)) bus ();

    sm_ram_arbiter #(.PORTS(PORTS), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sbQ[$];
    logic [31:0] modelMem [DEPTH];
    int          vectors     = 0;
    int          miscompares = 0;

    // Start an access on port p; the expected completion is queued in the
    // order the bench expects the grants to happen.
    task automatic drive(input int p, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit track);
        exp_t e;
        int   idx;
        bus.req[p]              = 1'b1;
        bus.we[p]               = w;
        bus.addr[32*p +: 32]    = a;
        bus.wdata[32*p +: 32]   = d;
        idx      = int'((a / 32'd4) % 32'(DEPTH));
        e.port   = p;
        e.isRead = !w;
        e.data   = w ? d : modelMem[idx];
        if (w) modelMem[idx] = d;
        if (track) sbQ.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (bus.ack !== 2'b00) begin
            miscompares++; $display("FAIL reset_ack: got %b want 00", bus.ack);
        end
        vectors++;
        if (bus.rdata !== 64'd0) begin
            miscompares++; $display("FAIL reset_rdata: got %h want 0", bus.rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.ack !== 2'b00) begin
            miscompares++; $display("FAIL idle_ack: got %b want 00", bus.ack);
        end
    endtask

    task automatic test_single();
        logic [1:0] expAck [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
        exp_t e;
        drive(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.ack !== expAck[c]) begin
                miscompares++; $display("FAIL single_ack[%0d]: got %b want %b", c, bus.ack, expAck[c]);
            end
            for (int p = 0; p < PORTS; p++) begin
                if (bus.ack[p] === 1'b1) begin
                    bus.req[p] = 1'b0;
                    vectors++;
                    if (sbQ.size() == 0) begin
                        miscompares++; $display("FAIL single_extra: ack on port%0d, none expected", p);
                    end else begin
                        e = sbQ.pop_front();
                        if (e.port != p || (e.isRead && bus.rdata[32*p +: 32] !== e.data)) begin
                            miscompares++;
                            $display("FAIL single_data: got port%0d %h want port%0d %h", p, bus.rdata[32*p +: 32], e.port, e.data);
                        end
                    end
                end
            end
            if (c == 1) drive(0, 1'b0, 32'h10, 32'h0, 1'b1);
        end
    endtask

    task automatic test_coherence();
        logic [1:0] expAck [3] = '{2'b10, 2'b01, 2'b00};
        exp_t e;
        drive(1, 1'b1, 32'h08, 32'h0000CAFE, 1'b1);
        drive(0, 1'b0, 32'h08, 32'h0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.ack !== expAck[c]) begin
                miscompares++; $display("FAIL coherence_ack[%0d]: got %b want %b", c, bus.ack, expAck[c]);
            end
            for (int p = 0; p < PORTS; p++) begin
                if (bus.ack[p] === 1'b1) begin
                    bus.req[p] = 1'b0;
                    vectors++;
                    if (sbQ.size() == 0) begin
                        miscompares++; $display("FAIL coherence_extra: ack on port%0d, none expected", p);
                    end else begin
                        e = sbQ.pop_front();
                        if (e.port != p || (e.isRead && bus.rdata[32*p +: 32] !== e.data)) begin
                            miscompares++;
                            $display("FAIL coherence_data: got port%0d %h want port%0d %h", p, bus.rdata[32*p +: 32], e.port, e.data);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] expAck [4] = '{2'b10, 2'b00, 2'b10, 2'b00};
        exp_t e;
        drive(1, 1'b1, 32'h100, 32'h11, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.ack !== expAck[c]) begin
                miscompares++; $display("FAIL wrap_ack[%0d]: got %b want %b", c, bus.ack, expAck[c]);
            end
            for (int p = 0; p < PORTS; p++) begin
                if (bus.ack[p] === 1'b1) begin
                    bus.req[p] = 1'b0;
                    vectors++;
                    if (sbQ.size() == 0) begin
                        miscompares++; $display("FAIL wrap_extra: ack on port%0d, none expected", p);
                    end else begin
                        e = sbQ.pop_front();
                        if (e.port != p || (e.isRead && bus.rdata[32*p +: 32] !== e.data)) begin
                            miscompares++;
                            $display("FAIL wrap_data: got port%0d %h want port%0d %h", p, bus.rdata[32*p +: 32], e.port, e.data);
                        end
                    end
                end
            end
            if (c == 1) drive(1, 1'b0, 32'h000, 32'h0, 1'b1);
        end
    endtask

    // Pointer is 0 on entry; both rounds must serve port0 before port1.
    task automatic test_contention();
        logic [1:0] expAck [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
        exp_t e;
        drive(0, 1'b0, 32'h100, 32'h0, 1'b1);
        drive(1, 1'b1, 32'h0C, 32'hC0FFEE00, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.ack !== expAck[c]) begin
                miscompares++; $display("FAIL contention_ack[%0d]: got %b want %b", c, bus.ack, expAck[c]);
            end
            for (int p = 0; p < PORTS; p++) begin
                if (bus.ack[p] === 1'b1) begin
                    bus.req[p] = 1'b0;
                    vectors++;
                    if (sbQ.size() == 0) begin
                        miscompares++; $display("FAIL contention_extra: ack on port%0d, none expected", p);
                    end else begin
                        e = sbQ.pop_front();
                        if (e.port != p || (e.isRead && bus.rdata[32*p +: 32] !== e.data)) begin
                            miscompares++;
                            $display("FAIL contention_data: got port%0d %h want port%0d %h", p, bus.rdata[32*p +: 32], e.port, e.data);
                        end
                    end
                end
            end
            if (c == 2) begin
                drive(0, 1'b0, 32'h0C, 32'h0, 1'b1);
                drive(1, 1'b0, 32'h10, 32'h0, 1'b1);
            end
        end
    endtask

    // Port0 keeps req high through its ack to chain a read after a write.
    task automatic test_back_to_back();
        logic [1:0] expAck [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
        exp_t e;
        drive(0, 1'b1, 32'h40, 32'h12345678, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.ack !== expAck[c]) begin
                miscompares++; $display("FAIL b2b_ack[%0d]: got %b want %b", c, bus.ack, expAck[c]);
            end
            for (int p = 0; p < PORTS; p++) begin
                if (bus.ack[p] === 1'b1) begin
                    bus.req[p] = 1'b0;
                    vectors++;
                    if (sbQ.size() == 0) begin
                        miscompares++; $display("FAIL b2b_extra: ack on port%0d, none expected", p);
                    end else begin
                        e = sbQ.pop_front();
                        if (e.port != p || (e.isRead && bus.rdata[32*p +: 32] !== e.data)) begin
                            miscompares++;
                            $display("FAIL b2b_data: got port%0d %h want port%0d %h", p, bus.rdata[32*p +: 32], e.port, e.data);
                        end
                    end
                end
            end
            if (c == 0) drive(0, 1'b0, 32'h40, 32'h0, 1'b1);
        end
    endtask

    // Reset lands right after the grant edge: the ack never shows, the
    // pointer returns to 0, and the written word stays in the RAM.
    task automatic test_reset_midop();
        logic [1:0] expAck [3] = '{2'b01, 2'b10, 2'b00};
        exp_t e;
        drive(0, 1'b1, 32'h30, 32'hA5A55A5A, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.ack !== 2'b00) begin
            miscompares++; $display("FAIL midop_ack: got %b want 00", bus.ack);
        end
        vectors++;
        if (bus.rdata !== 64'd0) begin
            miscompares++; $display("FAIL midop_rdata: got %h want 0", bus.rdata);
        end
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, 32'h30, 32'h0, 1'b1);
        drive(1, 1'b0, 32'h10, 32'h0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.ack !== expAck[c]) begin
                miscompares++; $display("FAIL midop_post_ack[%0d]: got %b want %b", c, bus.ack, expAck[c]);
            end
            for (int p = 0; p < PORTS; p++) begin
                if (bus.ack[p] === 1'b1) begin
                    bus.req[p] = 1'b0;
                    vectors++;
                    if (sbQ.size() == 0) begin
                        miscompares++; $display("FAIL midop_extra: ack on port%0d, none expected", p);
                    end else begin
                        e = sbQ.pop_front();
                        if (e.port != p || (e.isRead && bus.rdata[32*p +: 32] !== e.data)) begin
                            miscompares++;
                            $display("FAIL midop_data: got port%0d %h want port%0d %h", p, bus.rdata[32*p +: 32], e.port, e.data);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.lock  = '0;
        test_reset();
        test_single();
        test_coherence();
        test_wrap();
        test_contention();
        test_back_to_back();
        test_reset_midop();
        vectors++;
        if (sbQ.size() != 0) begin
            miscompares++; $display("FAIL leftover_expected: got %0d pending want 0", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sm_ram_arbiter.md
Name: sm_ram_arbiter

Overview:
- Parametrised successor to the two-port shared data RAM. Lets N CPU cores share one word-addressed data RAM through a round-robin arbiter.
- Each port uses a req/ack handshake, so cores stall instead of colliding. Write addressing is uniform across ports; there is no per-port bank forcing.
- Sits in the top level between the sm_cpu data ports (dmAddr/dmWe/dmWData/dmRData) and storage. Replaces the direct dual-port RAM.

Parameters:
- PORTS, 2, number of requesting ports (1..8).
- DEPTH, 64, RAM size in 32-bit words; power of two.
- AW, 6, word-index width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock (divided CPU clock).
- rst_n  in  1  asynchronous active-low reset.
- req  in  PORTS  per-port access request; held high until ack.
- we  in  PORTS  per-port write enable; qualifies req.
- addr  in  PORTS*32  per-port byte address; port i occupies bits [32*i +: 32].
- wdata  in  PORTS*32  per-port write data.
- lock  in  PORTS  per-port bus lock (only active with SM_RAM_ARB_LOCK_EN).
- rdata  out  PORTS*32  per-port read data, valid in ack cycle.
- ack  out  PORTS  one-cycle completion pulse per port.

Behaviour:
- Reset (async, rst_n=0):
  - ack=0, rdata=0, round-robin pointer=0, lock owner cleared, any pending grant discarded.
  - RAM contents are not cleared.
- Word index = addr[2 +: AW]. Bits [1:0] and bits above AW+1 are ignored, so indices wrap modulo DEPTH.
- Arbitration cycle T:
  - Eligible = req & ~ack_reg. A port being acked this cycle is masked, so its held request is not granted twice.
  - Grant the first eligible port at or after priority pointer P, searching upward and wrapping.
  - One access per cycle total.
- Access at grant edge:
  - Write: ram[idx] <= wdata_i.
  - Read: rdata_i <= ram[idx], registered.
- Ack timing:
  - ack[i]=1 in cycle T+1 for exactly one cycle.
  - rdata_i holds its value until the next read completes for that port.
- Pointer: after a grant to port g, P <= (g+1) mod PORTS. With no grant, P is unchanged.
- Latency and throughput:
  - Uncontended: req at T, ack at T+1.
  - A single port sustains at most one access per 2 cycles; the aggregate bus sustains one access per cycle.
- Requester rules:
  - addr, we and wdata are stable from req rise until ack.
  - req may drop in the ack cycle or stay high to start a new access, which becomes eligible at T+2.
  - Dropping req before ack is illegal; behaviour is undefined unless the port is already granted, in which case the access completes.
- Same-address ordering: accesses from different ports are serialised in grant order. A read granted after a write sees the new data.
- No requests: no RAM access, ack=0.

Optional Feature:
- Macro: SM_RAM_ARB_LOCK_EN.
- Defined:
  - If the granted port has lock[g]=1, it becomes lock owner.
  - While an owner exists, only the owner is eligible; other requesters wait with ack=0.
  - Ownership ends in the first cycle the owner's lock=0. Arbitration then resumes from P.
  - This enables atomic read-modify-write for spinlocks between cores.
- Undefined: the lock input is ignored; pure round-robin.

Decomposition:
- sm_config.vh holds:
  - SM_RAM_ARB_PORTS and SM_RAM_ARB_DEPTH defaults.
  - Word-index offset constant (2).
  - SM_RAM_ARB_LOCK_EN.
- Sub-module sm_rr_arbiter (PORTS-wide): inputs eligible vector and pointer; outputs one-hot grant, grant index and valid. It is purely combinational with the pointer register in the parent, or holds the pointer register itself. Implementer's choice; the interface is fixed as above.
- RAM array is inline in sm_ram_arbiter.

Test Plan:
- Single port, PORTS=2: port0 write addr 0x10 data 0xDEADBEEF, then read 0x10 -> ack one cycle after each req; rdata0=0xDEADBEEF.
- Contention: both ports req at same cycle, P=0 -> port0 acked at T+1, port1 at T+2, P ends at 0.
- Cross-port coherence: port1 writes 0x0000CAFE to addr 0x08 while port0 reads 0x08 in the same cycle with P=1 -> port1 first; port0 read returns 0x0000CAFE.
- Wrap: DEPTH=64, write 0x11 to addr 0x100 (index 64) -> read addr 0x000 returns 0x11.
- Reset mid-op: assert rst_n=0 in the cycle between grant and ack -> ack stays 0, P=0; after release, the written word is retained if the write edge occurred.
- With SM_RAM_ARB_LOCK_EN, PORTS=3: port2 lock=1 with 3 back-to-back accesses, ports 0/1 requesting -> ports 0/1 get no ack until port2 lock=0; then port0 granted next.
